// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: command/response codes and bridge state encoding shared by the UART bus bridge.
package uart_bridge_pkg;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP} state_e;
endpackage

// File: rtl/uart_bridge_txseq.sv
// uart_bridge_txseq: sends a 1- or 4-byte response MSB first, pacing every byte on tx_busy.
module uart_bridge_txseq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [31:0] word_i,
    input  logic [2:0]  len_i,
    input  logic        tx_busy_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_wr_o,
    output logic        active_o,
    output logic        done_o
);
    logic        active_q, active_d, tx_wr_q, tx_wr_d, done_q, done_d;
    logic [2:0]  left_q, left_d;
    logic [1:0]  guard_q, guard_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  tx_data_q, tx_data_d;

    always_comb begin
        active_d  = active_q;
        left_d    = left_q;
        word_d    = word_q;
        guard_d   = guard_q == 2'd0 ? 2'd0 : guard_q - 2'd1;
        tx_wr_d   = 1'b0;
        tx_data_d = tx_data_q;
        done_d    = 1'b0;
        if (start_i && !active_q) begin
            active_d = 1'b1;
            left_d   = len_i;
            word_d   = len_i == 3'd1 ? {word_i[7:0], 24'h0} : word_i;
        end else if (active_q && guard_q == 2'd0) begin
            if (left_q == 3'd0) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end else if (!tx_busy_i) begin
                // busy is blind during the pulse and the cycle after it
                tx_wr_d   = 1'b1;
                tx_data_d = word_q[31:24];
                word_d    = {word_q[23:0], 8'h00};
                left_d    = left_q - 3'd1;
                guard_d   = 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q  <= 1'b0;
            left_q    <= 3'd0;
            word_q    <= 32'h0;
            guard_q   <= 2'd0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            active_q  <= active_d;
            left_q    <= left_d;
            word_q    <= word_d;
            guard_q   <= guard_d;
            tx_wr_q   <= tx_wr_d;
            tx_data_q <= tx_data_d;
            done_q    <= done_d;
        end
    end

    assign tx_data_o = tx_data_q;
    assign tx_wr_o   = tx_wr_q;
    assign active_o  = active_q;
    assign done_o    = done_q;
endmodule

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: decodes UART write/read frames into single 32-bit bus accesses and replies
// with ACK, NAK or the read word.
module uart_bus_bridge
    import uart_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 270000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    input  logic        rx_error,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d, rx_ack_q, rx_ack_d, ack_dly_q, start_q, start_d;
    logic        bus_we_q, bus_we_d, bus_re_q, bus_re_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, resp_word_q, resp_word_d;
    logic [2:0]  resp_len_q, resp_len_d;
    logic [TW-1:0] timer_q, timer_d;
    logic        take, got, timeout, tx_active, tx_done;

    assign timeout = timer_q >= TW'(TIMEOUT_CYCLES - 1);
    // the NAK path shares the sequencer, so IDLE only takes bytes once it is free
    assign take = !rx_ack_q && !ack_dly_q &&
                  (state_q == ADDR || state_q == DATA || (state_q == IDLE && !tx_active && !start_q));
    assign got  = take && (rx_avail || rx_error);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_word_d = resp_word_q;
        resp_len_d  = resp_len_q;
        start_d     = 1'b0;
        bus_we_d    = 1'b0;
        bus_re_d    = 1'b0;
        rx_ack_d    = got;
        if (got && rx_error) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (got) begin
                    if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
                        state_d = ADDR;
                        cnt_d   = 2'd0;
                        wr_d    = rx_data == CMD_WRITE;
                    end else begin
                        start_d     = 1'b1;
                        resp_word_d = {24'h0, RSP_NAK};
                        resp_len_d  = 3'd1;
                    end
                end
                ADDR: if (got) begin
                    addr_d = {addr_q[23:0], rx_data};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = wr_q ? DATA : BUS_REQ;
                end else if (timeout) state_d = IDLE;
                DATA: if (got) begin
                    wdata_d = {wdata_q[23:0], rx_data};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = BUS_REQ;
                end else if (timeout) state_d = IDLE;
                BUS_REQ: begin
                    bus_we_d = wr_q;
                    bus_re_d = !wr_q;
                    state_d  = BUS_WAIT;
                end
                BUS_WAIT: if (bus_ready || timeout) begin
                    state_d     = RESP;
                    start_d     = 1'b1;
                    resp_len_d  = bus_ready && !wr_q ? 3'd4 : 3'd1;
                    resp_word_d = !bus_ready ? {24'h0, RSP_NAK} : wr_q ? {24'h0, RSP_ACK} : bus_rdata;
                end
                RESP: if (tx_done) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        timer_d = (state_d != state_q || got) ? '0 :
                  timer_q == TW'(TIMEOUT_CYCLES) ? timer_q : timer_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            wr_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            resp_word_q <= 32'h0;
            resp_len_q  <= 3'd0;
            start_q     <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_re_q    <= 1'b0;
            rx_ack_q    <= 1'b0;
            ack_dly_q   <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_word_q <= resp_word_d;
            resp_len_q  <= resp_len_d;
            start_q     <= start_d;
            bus_we_q    <= bus_we_d;
            bus_re_q    <= bus_re_d;
            rx_ack_q    <= rx_ack_d;
            ack_dly_q   <= rx_ack_q;
            timer_q     <= timer_d;
        end
    end

    uart_bridge_txseq u_txseq (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_q),
        .word_i    (resp_word_q),
        .len_i     (resp_len_q),
        .tx_busy_i (tx_busy),
        .tx_data_o (tx_data),
        .tx_wr_o   (tx_wr),
        .active_o  (tx_active),
        .done_o    (tx_done)
    );

    assign rx_ack    = rx_ack_q;
    assign bus_we    = bus_we_q;
    assign bus_re    = bus_re_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
endmodule
